// File: rtl/execute_muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning HI/LO, with a stall request to the hazard unit.
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module execute_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic [2:0]       op_e,
  input  logic             valid_e,
  input  logic             mf_read_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_md
);

  // state | meaning
  // IDLE  | no operation in flight; accepts muldiv and MTHI/MTLO
  // MUL   | shift-add multiply, one step per cycle
  // DIV   | restoring divide, one step per cycle
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, step_acc;
  logic [WIDTH-1:0]   opnd, opnd_nxt;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt, res_hi, res_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, rem_sh, diff;

`ifdef MULDIV_SIGNED_EN
  logic signed_op, neg_q, neg_r, neg_q_nxt, neg_r_nxt;
  logic [2*WIDTH-1:0] prod_neg;

  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign a_mag     = (signed_op && srca_e[WIDTH-1]) ? -srca_e : srca_e;
  assign b_mag     = (signed_op && srcb_e[WIDTH-1]) ? -srcb_e : srcb_e;
  assign neg_q_nxt = signed_op && (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
  assign neg_r_nxt = signed_op && srca_e[WIDTH-1];
  assign prod_neg  = -step_acc;
`else
  assign a_mag = srca_e;
  assign b_mag = srcb_e;
`endif

  // Multiply: {upper, multiplier} shifts right; divide: {remainder, quotient} shifts left.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    step_acc = '0;
    if (state == MUL)
      step_acc = {sum, acc[WIDTH-1:1]};
    else if (diff[WIDTH])
      step_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    res_hi = step_acc[2*WIDTH-1:WIDTH];
    res_lo = step_acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (state == MUL) begin
      if (neg_q) {res_hi, res_lo} = prod_neg;
    end else begin
      if (neg_q) res_lo = -step_acc[WIDTH-1:0];
      if (neg_r) res_hi = -step_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    opnd_nxt  = opnd;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (valid_e) begin
          case (op_e)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              acc_nxt   = {{WIDTH{1'b0}}, a_mag};
              opnd_nxt  = b_mag;
              cnt_nxt   = CNT_W'(WIDTH);
              state_nxt = ((op_e == OP_MULTU) || (op_e == OP_MULT)) ? MUL : DIV;
            end
            OP_MTHI: hi_nxt = srca_e;
            OP_MTLO: lo_nxt = srca_e;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        acc_nxt = step_acc;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_nxt    = res_hi;
          lo_nxt    = res_lo;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      opnd  <= opnd_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && valid_e) begin
      neg_q <= neg_q_nxt;
      neg_r <= neg_r_nxt;
    end
  end
`endif

  assign busy     = (state != IDLE);
  assign stall_md = busy & ((valid_e & (op_e != 3'b000) & (op_e != 3'b111)) | mf_read_e);

endmodule
